// File: rtl/adc_frame_fifo_if.sv
// Output stream of the ADC frame FIFO: one channel word per valid/ready handshake.
interface adc_frame_fifo_if #(
    parameter int adc_bits  = 24,
    parameter int chan_bits = 3
);
    logic [adc_bits-1:0]  out_data;
    logic [chan_bits-1:0] out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_chan, output out_valid, input out_ready);
    modport slave  (input out_data, input out_chan, input out_valid, output out_ready);
endinterface

// File: rtl/adc_frame_fifo.sv
// Parallel multi-channel ADC deserializer; each completed frame is captured in one
// shot and drained as a channel-ordered stream through a shift chain of stages.
module adc_frame_fifo #(
    parameter int adc_bits     = 24,
    parameter int num_channels = 8,
    parameter int chan_bits    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [num_channels-1:0] in_bits,
    input  logic                    shift_ena,
    input  logic                    frame_done,
    input  logic                    clear_flags,
    adc_frame_fifo_if.master        stream,
    output logic                    overrun,
    output logic                    frame_error
);
    localparam int cnt_w  = $clog2(adc_bits + 1);
    localparam int word_w = $clog2(num_channels + 1);
    localparam logic [cnt_w-1:0]  cnt_max    = '1;
    localparam logic [cnt_w-1:0]  cnt_target = cnt_w'(adc_bits);
    localparam logic [word_w-1:0] word_full  = word_w'(num_channels);
    localparam logic [word_w-1:0] word_one   = word_w'(1);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [adc_bits-1:0]  shifter_reg [num_channels];
    logic [adc_bits-1:0]  stage_reg   [num_channels];
    logic [cnt_w-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [word_w-1:0]    word_cnt_reg, word_cnt_next;
    logic [chan_bits-1:0] chan_reg, chan_next;
    state_t               state_reg, state_next;
    logic                 overrun_reg, overrun_next;
    logic                 frame_error_reg, frame_error_next;
    logic                 advance;
    logic                 load_frame;

    // A new frame fits only if the old one is gone, or its last word leaves this cycle.
    always_comb begin
        advance       = (state_reg == DRAIN) && stream.out_ready;
        load_frame    = frame_done && ((word_cnt_reg == '0) ||
                                       ((word_cnt_reg == word_one) && advance));
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        chan_next     = chan_reg;
        if (load_frame) begin
            state_next    = DRAIN;
            word_cnt_next = word_full;
            chan_next     = '0;
        end else begin
            case (state_reg)
                DRAIN: begin
                    if (advance) begin
                        if (word_cnt_reg == word_one) begin
                            state_next    = IDLE;
                            word_cnt_next = '0;
                            chan_next     = '0;
                        end else begin
                            word_cnt_next = word_cnt_reg - word_one;
                            chan_next     = chan_reg + chan_bits'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Bit counter restarts on frame_done, counting a coincident shift as the first bit.
    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (frame_done) begin
            bit_cnt_next = shift_ena ? cnt_w'(1) : '0;
        end else if (shift_ena && (bit_cnt_reg != cnt_max)) begin
            bit_cnt_next = bit_cnt_reg + cnt_w'(1);
        end
    end

    // Sticky flags: a set condition overrides a simultaneous clear.
    always_comb begin
        overrun_next     = overrun_reg;
        frame_error_next = frame_error_reg;
        if (frame_done && !load_frame) begin
            overrun_next = 1'b1;
        end else if (clear_flags) begin
            overrun_next = 1'b0;
        end
        if (frame_done && (bit_cnt_reg != cnt_target)) begin
            frame_error_next = 1'b1;
        end else if (clear_flags) begin
            frame_error_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            word_cnt_reg    <= '0;
            chan_reg        <= '0;
            bit_cnt_reg     <= '0;
            overrun_reg     <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            word_cnt_reg    <= word_cnt_next;
            chan_reg        <= chan_next;
            bit_cnt_reg     <= bit_cnt_next;
            overrun_reg     <= overrun_next;
            frame_error_reg <= frame_error_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < num_channels; gi++) begin : g_chan
            always_ff @(posedge clock) begin
                if (reset) begin
                    shifter_reg[gi] <= '0;
                end else if (shift_ena) begin
                    shifter_reg[gi] <= {shifter_reg[gi][adc_bits-2:0], in_bits[gi]};
                end
            end

            // Capture sees the pre-shift shifter value; the top stage backfills zeros.
            if (gi == num_channels - 1) begin : g_top
                always_ff @(posedge clock) begin
                    if (reset) begin
                        stage_reg[gi] <= '0;
                    end else if (load_frame) begin
                        stage_reg[gi] <= shifter_reg[gi];
                    end else if (advance) begin
                        stage_reg[gi] <= '0;
                    end
                end
            end else begin : g_mid
                always_ff @(posedge clock) begin
                    if (reset) begin
                        stage_reg[gi] <= '0;
                    end else if (load_frame) begin
                        stage_reg[gi] <= shifter_reg[gi];
                    end else if (advance) begin
                        stage_reg[gi] <= stage_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    assign stream.out_data  = stage_reg[0];
    assign stream.out_chan  = chan_reg;
    assign stream.out_valid = (state_reg == DRAIN);
    assign overrun          = overrun_reg;
    assign frame_error      = frame_error_reg;
endmodule

// File: doc/adc_frame_fifo.md
# adc_frame_fifo

Multi-channel successor to the single-channel ADC deserializer and FIFO stage. The block deserializes `num_channels` ADC serial inputs in parallel. At the end of each conversion frame it captures every channel word at once. It then drains the words out as a sequential stream, one channel per accepted handshake. It sits between the ADC bit-clock/frame timing logic and the downstream sample packer, replacing a hand-built chain of per-channel register stages.

## Interface
- `adc_bits`, default 24, width of one ADC sample word (≥2).
- `num_channels`, default 8, number of ADC serial inputs (≥1).
- `chan_bits`, default 3, width of the channel index; requires 2^chan_bits ≥ num_channels.
- `clock`, input, 1, the single clock for all logic.
- `reset`, input, 1, synchronous, active-high.
- `in_bits`, input, num_channels, one ADC serial bit per channel; bit i belongs to channel i.
- `shift_ena`, input, 1, shift `in_bits` into all shifters on this clock.
- `frame_done`, input, 1, single-cycle pulse marking the end of a conversion frame.
- `clear_flags`, input, 1, clears the sticky error flags.
- `out_data`, output, adc_bits, current stream word.
- `out_chan`, output, chan_bits, channel index of `out_data`.
- `out_valid`, output, 1, `out_data`/`out_chan` hold a word not yet accepted.
- `out_ready`, input, 1, downstream accepts the word when `out_valid` and `out_ready` are both high.
- `overrun`, output, 1, sticky: a frame was dropped because the drain was incomplete.
- `frame_error`, output, 1, sticky: a frame ended with a shift count other than adc_bits.

## Operation
- Shifters: one per channel, adc_bits wide, MSB first. When `shift_ena` is high, each shifter does `shifter <= {shifter[adc_bits-2:0], in_bits[i]}`.
- Bit counter: counts `shift_ena` cycles since the last `frame_done`. It saturates at 2^ceil(log2(adc_bits+1))-1 and never wraps.
- On `frame_done`:
  - The captured value is the shifter contents before any same-cycle shift.
  - The bit counter restarts at 1 if `shift_ena` is also high, else at 0.
  - If the counter value before the restart ≠ adc_bits, set `frame_error`. The frame is still captured if the overrun rule allows it.
- Capture/overrun rule: a frame is accepted when no words remain. It is also accepted when the only remaining word is accepted in that same cycle. Otherwise the new frame is discarded, `overrun` is set, and the drain of the old frame continues unaffected.
- Acceptance of a frame:
  - All num_channels output stages load in parallel.
  - The word counter is set to num_channels.
  - `out_chan` is set to 0.
- Drain is a FIFO shift chain, states IDLE (count 0) and DRAIN (count > 0).
  - `out_data` is stage 0 and `out_valid` = (count ≠ 0).
  - On each handshake: stage[i] <= stage[i+1], the top stage loads 0, count decrements, and `out_chan` increments.
  - After the last word is accepted, `out_chan` returns to 0.
- Flags:
  - `clear_flags` clears both flags.
  - If a set condition occurs in the same cycle as `clear_flags`, the set wins.
  - Flags never affect data flow.
- Reset clears: shifters, stages, bit counter, word counter, `out_data`=0, `out_chan`=0, `out_valid`=0, `overrun`=0, `frame_error`=0.
  - Reset mid-drain discards all remaining words.
  - `frame_done` asserted during reset is ignored.

## Timing
- Capture latency: `frame_done` in cycle T → `out_valid`=1 with channel 0 in cycle T+1.
- With `out_ready` held high, one word is accepted per cycle.
  - Channel k is presented in cycle T+1+k.
  - `out_valid` falls in cycle T+1+num_channels.
- `out_data` and `out_chan` are stable while `out_valid` is high and `out_ready` is low.
- Back-to-back capture: a final-word handshake and `frame_done` in the same cycle C give channel 0 of the new frame at C+1, with no bubble and no overrun.
- Minimum frame period without overrun: num_channels cycles of `out_ready` between `frame_done` pulses.
- All outputs are registered; no combinational path from `out_ready` to `out_valid`.

## Test plan
- Single frame: channels i=0..7 send word 24'hA00000+i, MSB first, over 24 `shift_ena` cycles, then `frame_done`; `out_ready`=1 → stream 24'hA00000..24'hA00007 with `out_chan` 0..7 on consecutive cycles, `out_valid` low afterward, both flags 0.
- Backpressure: the same frame with `out_ready` toggling 1,0,0,1 → every word is held stable while stalled, no word is lost or duplicated, and order stays 0..7.
- Overrun: a second `frame_done` when 3 words remain → `overrun`=1, the remaining old words 5,6,7 still arrive, and the new frame is never output. `clear_flags` → `overrun`=0.
- Back-to-back: a second `frame_done` coincident with acceptance of channel 7 → the new frame's channel 0 appears on the next cycle and `overrun` stays 0.
- Count error: `frame_done` after 23 shifts → `frame_error`=1 and the frame is still output. With `frame_done` and `shift_ena` in the same cycle, the next frame is counted from 1, and 23 more shifts give no error.
- Reset mid-drain: assert `reset` one cycle after word 2 is accepted → the next cycle shows `out_valid`=0, `out_chan`=0, `out_data`=0, and flags 0. A following clean frame drains correctly.
